// File: rtl/ps2_keyboard_receiver.sv
// PS/2 keyboard receiver: synchronizes and filters the device clock, deserializes
// odd-parity frames, folds E0/F0 prefixes into flags and strobes one event per key.
module ps2_keyboard_receiver #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] data,
    output logic       extended,
    output logic       released,
    output logic       valid,
    output logic       error
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [7:0] CODE_EXT = 8'hE0;
    localparam logic [7:0] CODE_BRK = 8'hF0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    // Input synchronizers (lines idle high)
    logic          clk_meta_q;
    logic          clk_sync_q;
    logic          dat_meta_q;
    logic          dat_sync_q;

    // Clock glitch filter
    logic          filt_q, filt_d;
    logic [FW-1:0] filt_cnt_q, filt_cnt_d;
    logic          filt_prev_q;
    logic          sample_ev;

    // Frame deserializer
    state_t        state_q, state_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          par_q, par_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic          byte_done;
    logic          frame_fail;
    logic          timeout_hit;

    // Byte layer and outputs
    logic          ext_pend_q, ext_pend_d;
    logic          brk_pend_q, brk_pend_d;
    logic [7:0]    data_q, data_d;
    logic          ext_q, ext_d;
    logic          rel_q, rel_d;
    logic          valid_q, valid_d;
    logic          error_q, error_d;

    // Two-flop synchronizers for both asynchronous PS/2 lines
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_meta_q <= 1'b1;
            clk_sync_q <= 1'b1;
            dat_meta_q <= 1'b1;
            dat_sync_q <= 1'b1;
        end else begin
            clk_meta_q <= ps2_clk;
            clk_sync_q <= clk_meta_q;
            dat_meta_q <= ps2_data;
            dat_sync_q <= dat_meta_q;
        end
    end

    // Filtered clock follows the synchronized clock only after a stable run
    always_comb begin
        filt_d     = filt_q;
        filt_cnt_d = '0;
        if (clk_sync_q != filt_q) begin
            if (filt_cnt_q == FW'(FILTER_LEN - 1)) begin
                filt_d = clk_sync_q;
            end else begin
                filt_cnt_d = filt_cnt_q + 1'b1;
            end
        end
    end

    // Filter state and previous filtered level for edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            filt_q      <= 1'b1;
            filt_cnt_q  <= '0;
            filt_prev_q <= 1'b1;
        end else begin
            filt_q      <= filt_d;
            filt_cnt_q  <= filt_cnt_d;
            filt_prev_q <= filt_q;
        end
    end

    assign sample_ev = filt_prev_q & ~filt_q;

    // Frame FSM next state, timeout supervision and byte-layer decode
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        par_d       = par_q;
        to_cnt_d    = to_cnt_q;
        byte_done   = 1'b0;
        frame_fail  = 1'b0;
        timeout_hit = 1'b0;
        ext_pend_d  = ext_pend_q;
        brk_pend_d  = brk_pend_q;
        data_d      = data_q;
        ext_d       = ext_q;
        rel_d       = rel_q;
        valid_d     = 1'b0;
        error_d     = 1'b0;

        if (state_q == ST_IDLE || sample_ev) begin
            to_cnt_d = '0;
        end else begin
            to_cnt_d = to_cnt_q + 1'b1;
        end

        if (sample_ev) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (!dat_sync_q) begin
                        state_d   = ST_DATA;
                        bit_cnt_d = 3'd0;
                    end
                end
                ST_DATA: begin
                    shift_d   = {dat_sync_q, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = ST_PARITY;
                    end
                end
                ST_PARITY: begin
                    par_d   = dat_sync_q;
                    state_d = ST_STOP;
                end
                ST_STOP: begin
                    state_d = ST_IDLE;
                    if (dat_sync_q && (^{shift_q, par_q})) begin
                        byte_done = 1'b1;
                    end else begin
                        frame_fail = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end else if (state_q != ST_IDLE &&
                     to_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
            timeout_hit = 1'b1;
            state_d     = ST_IDLE;
            to_cnt_d    = '0;
        end

        unique case (1'b1)
            byte_done: begin
                if (shift_q == CODE_EXT) begin
                    ext_pend_d = 1'b1;
                end else if (shift_q == CODE_BRK) begin
                    brk_pend_d = 1'b1;
                end else begin
                    data_d     = shift_q;
                    ext_d      = ext_pend_q;
                    rel_d      = brk_pend_q;
                    valid_d    = 1'b1;
                    ext_pend_d = 1'b0;
                    brk_pend_d = 1'b0;
                end
            end
            (frame_fail | timeout_hit): begin
                error_d    = 1'b1;
                ext_pend_d = 1'b0;
                brk_pend_d = 1'b0;
            end
            default: ;
        endcase
    end

    // Frame, prefix and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= 3'd0;
            shift_q    <= 8'h00;
            par_q      <= 1'b0;
            to_cnt_q   <= '0;
            ext_pend_q <= 1'b0;
            brk_pend_q <= 1'b0;
            data_q     <= 8'h00;
            ext_q      <= 1'b0;
            rel_q      <= 1'b0;
            valid_q    <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            par_q      <= par_d;
            to_cnt_q   <= to_cnt_d;
            ext_pend_q <= ext_pend_d;
            brk_pend_q <= brk_pend_d;
            data_q     <= data_d;
            ext_q      <= ext_d;
            rel_q      <= rel_d;
            valid_q    <= valid_d;
            error_q    <= error_d;
        end
    end

    assign data     = data_q;
    assign extended = ext_q;
    assign released = rel_q;
    assign valid    = valid_q;
    assign error    = error_q;

endmodule

// File: tb/tb_ps2_keyboard_receiver.sv
// Bench for ps2_keyboard_receiver: drives PS/2 frames and checks every strobe
// and every held output against a key-event level model.
module tb_ps2_keyboard_receiver;

    localparam int FL   = 8;
    localparam int TO   = 1000;
    localparam int HALF = 80;

    logic       clk = 1'b0;
    logic       rst;
    logic       ps2_clk;
    logic       ps2_data;
    logic [7:0] data;
    logic       extended;
    logic       released;
    logic       valid;
    logic       error;

    always #5 clk = ~clk;

    ps2_keyboard_receiver #(
        .FILTER_LEN    (FL),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .ps2_clk (ps2_clk),
        .ps2_data(ps2_data),
        .data    (data),
        .extended(extended),
        .released(released),
        .valid   (valid),
        .error   (error)
    );

    typedef struct {
        bit         is_err;
        logic [7:0] d;
        bit         e;
        bit         r;
    } ev_t;

    ev_t        exp_q[$];
    int         npass = 0;
    int         ntot  = 0;
    bit         chk_en = 0;
    bit         m_ext = 0;
    bit         m_brk = 0;
    logic [7:0] h_data = 8'h00;
    bit         h_ext = 0;
    bit         h_rel = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        ntot++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Key-event model: what a complete frame means to the keyboard user
    task automatic model_frame(input logic [7:0] b, input logic p,
                               input logic stop);
        ev_t ev;
        int  ones;
        ones = $countones(b) + int'(p);
        if (!stop || (ones % 2) == 0) begin
            ev = '{is_err: 1, d: 8'h00, e: 0, r: 0};
            exp_q.push_back(ev);
            m_ext = 0;
            m_brk = 0;
        end else if (b == 8'hE0) begin
            m_ext = 1;
        end else if (b == 8'hF0) begin
            m_brk = 1;
        end else begin
            ev = '{is_err: 0, d: b, e: m_ext, r: m_brk};
            exp_q.push_back(ev);
            m_ext = 0;
            m_brk = 0;
        end
    endtask

    task automatic model_abort();
        ev_t ev;
        ev = '{is_err: 1, d: 8'h00, e: 0, r: 0};
        exp_q.push_back(ev);
        m_ext = 0;
        m_brk = 0;
    endtask

    task automatic glitch();
        ps2_clk = 1'b0;
        cyc(FL - 2);
        ps2_clk = 1'b1;
    endtask

    // One bit cell: data set while high, then a low phase; on the stop bit
    // the expected event must be delivered before the low phase ends
    task automatic ps2_bit(input logic b, input bit last, input bit glt);
        ps2_data = b;
        if (glt) begin
            cyc(10);
            glitch();
            cyc(HALF / 2 - 10 - (FL - 2));
        end else begin
            cyc(HALF / 2);
        end
        ps2_clk = 1'b0;
        cyc(HALF);
        if (last) chk("stop_latency", exp_q.size(), 0);
        ps2_clk = 1'b1;
        cyc(HALF / 2);
    endtask

    task automatic send_frame(input logic [7:0] b, input bit flip_par,
                              input int glitch_bit);
        logic [10:0] f;
        logic        p;
        p = ~(^b) ^ flip_par;
        f = {1'b1, p, b, 1'b0};
        for (int i = 0; i < 11; i++) begin
            if (i == 10) model_frame(b, p, f[10]);
            ps2_bit(f[i], i == 10, i == glitch_bit);
        end
    endtask

    task automatic send_partial(input logic [7:0] b, input int nbits);
        ps2_bit(1'b0, 0, 0);
        for (int i = 0; i < nbits; i++) ps2_bit(b[i], 0, 0);
    endtask

    task automatic check_held(input logic [7:0] d, input bit e, input bit r,
                              input string tag);
        chk({tag, "_data"}, data, d);
        chk({tag, "_ext"}, extended, e);
        chk({tag, "_rel"}, released, r);
    endtask

    // Per-cycle compare of strobes and held outputs against the model
    always @(negedge clk) begin
        if (chk_en && !rst) begin
            chk("strobe_exclusive", valid & error, 0);
            if (valid || error) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_strobe", {valid, error}, 0);
                end else begin
                    ev_t ev;
                    ev = exp_q.pop_front();
                    chk("strobe_kind", error, ev.is_err);
                    if (valid && !ev.is_err) begin
                        chk("ev_data", data, ev.d);
                        chk("ev_ext", extended, ev.e);
                        chk("ev_rel", released, ev.r);
                        h_data = ev.d;
                        h_ext  = ev.e;
                        h_rel  = ev.r;
                    end
                end
            end
            if (!valid) begin
                chk("hold_data", data, h_data);
                chk("hold_ext", extended, h_ext);
                chk("hold_rel", released, h_rel);
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic p45;
        rst      = 1'b1;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        cyc(3);
        chk("rst_data", data, 8'h00);
        chk("rst_ext", extended, 0);
        chk("rst_rel", released, 0);
        chk("rst_valid", valid, 0);
        chk("rst_error", error, 0);
        rst = 1'b0;
        cyc(20);
        chk_en = 1;

        p45 = ~(^8'h45);
        chk("parity_0x45", p45, 1'b0);

        send_frame(8'h45, 0, -1);
        cyc(20);
        check_held(8'h45, 0, 0, "press");

        send_frame(8'hF0, 0, -1);
        cyc(20);
        check_held(8'h45, 0, 0, "after_f0");
        send_frame(8'h16, 0, -1);
        cyc(20);
        check_held(8'h16, 0, 1, "break");

        send_frame(8'hE0, 0, -1);
        send_frame(8'hF0, 0, -1);
        send_frame(8'h70, 0, -1);
        cyc(20);
        check_held(8'h70, 1, 1, "ext_rel");

        send_frame(8'hF0, 0, -1);
        send_frame(8'h45, 1, -1);
        cyc(20);
        check_held(8'h70, 1, 1, "par_err");
        send_frame(8'h16, 0, -1);
        cyc(20);
        check_held(8'h16, 0, 0, "err_clr");

        cyc(50);
        glitch();
        cyc(50);
        send_frame(8'h1C, 0, 4);
        cyc(20);
        check_held(8'h1C, 0, 0, "glitch");

        send_frame(8'hE0, 0, -1);
        send_partial(8'h1C, 4);
        model_abort();
        cyc(TO + 200);
        chk("timeout_seen", exp_q.size(), 0);
        send_frame(8'h5A, 0, -1);
        cyc(20);
        check_held(8'h5A, 0, 0, "after_to");
        send_frame(8'h1C, 0, -1);
        cyc(20);
        check_held(8'h1C, 0, 0, "to_1c");

        send_frame(8'hE0, 0, -1);
        send_partial(8'h45, 5);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_data", data, 8'h00);
        chk("arst_ext", extended, 0);
        chk("arst_rel", released, 0);
        chk("arst_valid", valid, 0);
        chk("arst_error", error, 0);
        exp_q.delete();
        m_ext  = 0;
        m_brk  = 0;
        h_data = 8'h00;
        h_ext  = 0;
        h_rel  = 0;
        cyc(3);
        rst = 1'b0;
        cyc(20);
        send_frame(8'h45, 0, -1);
        cyc(20);
        check_held(8'h45, 0, 0, "post_rst");

        chk("queue_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
